// File: rtl/m68k_region_decoder.sv
`default_nettype none
// ============================================================================
// Module   : m68k_region_decoder
// Brief    : Registered, table-driven 68000 address decoder with per-region
//            wait states and DTACK generation. Optional macro CS_BUSERR_EN
//            turns unmapped accesses into a timed bus error.
// Revision : 1.0 - initial release
// ============================================================================
module m68k_region_decoder #(
  parameter int NUM_REGIONS = 24,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]              cfg_base,
  input  logic [4:0]                     cfg_shift,
  input  logic [WAIT_W-1:0]              cfg_wait,
  input  logic                           cfg_valid,
  input  logic [ADDR_W-1:0]              cpu_a,
  input  logic                           cpu_as_n,
  output logic [NUM_REGIONS-1:0]         cs,
  output logic [$clog2(NUM_REGIONS)-1:0] hit_idx,
  output logic                           hit,
  output logic                           dtack_n,
  output logic                           berr_n
);
  localparam int IDX_W = $clog2(NUM_REGIONS);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
`ifdef CS_BUSERR_EN
  localparam logic [1:0] S_BERR = 2'd3;
`endif

  logic [ADDR_W-1:0]      base_q  [NUM_REGIONS];
  logic [ADDR_W-1:0]      base_d  [NUM_REGIONS];
  logic [4:0]             shift_q [NUM_REGIONS];
  logic [4:0]             shift_d [NUM_REGIONS];
  logic [WAIT_W-1:0]      wait_q  [NUM_REGIONS];
  logic [WAIT_W-1:0]      wait_d  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] valid_q, valid_d;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
  logic                   hit_q, hit_d;
  logic                   dtack_n_q, dtack_n_d;

  logic                   match_any;
  logic [IDX_W-1:0]       match_idx;

  // Table update; writes to indices past the last region are dropped.
  always_comb begin
    base_d  = base_q;
    shift_d = shift_q;
    wait_d  = wait_q;
    valid_d = valid_q;
    if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
      base_d[cfg_idx]  = cfg_base;
      shift_d[cfg_idx] = cfg_shift;
      wait_d[cfg_idx]  = cfg_wait;
      valid_d[cfg_idx] = cfg_valid;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (valid_q[i] && ((cpu_a >> shift_q[i]) == (base_q[i] >> shift_q[i]))) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= '0;
        shift_q[i] <= '0;
        wait_q[i]  <= '0;
      end
      valid_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cs_q      <= '0;
      hit_idx_q <= '0;
      hit_q     <= 1'b0;
      dtack_n_q <= 1'b1;
    end else begin
      base_q    <= base_d;
      shift_q   <= shift_d;
      wait_q    <= wait_d;
      valid_q   <= valid_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      hit_idx_q <= hit_idx_d;
      hit_q     <= hit_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cpu_as_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (cnt_q == '0) begin
`ifdef CS_BUSERR_EN
            state_d = hit_q ? S_ACK : S_BERR;
`else
            state_d = S_ACK;
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cs_d      = cs_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    dtack_n_d = dtack_n_q;
    cnt_d     = cnt_q;
    if (cpu_as_n) begin
      cs_d      = '0;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      dtack_n_d = 1'b1;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match_any) begin
            cs_d      = NUM_REGIONS'(1) << match_idx;
            hit_d     = 1'b1;
            hit_idx_d = match_idx;
            cnt_d     = CNT_W'(wait_q[match_idx]);
          end else begin
`ifdef CS_BUSERR_EN
            cnt_d = CNT_W'(TIMEOUT - 1);
`else
            cnt_d = '0;
`endif
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
`ifdef CS_BUSERR_EN
            if (hit_q) dtack_n_d = 1'b0;
`else
            dtack_n_d = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CS_BUSERR_EN
  logic berr_n_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) berr_n_q <= 1'b1;
    else       berr_n_q <= cpu_as_n || !(state_d == S_BERR);
  end
  assign berr_n = berr_n_q;
`else
  assign berr_n = 1'b1;
`endif

  assign cs      = cs_q;
  assign hit_idx = hit_idx_q;
  assign hit     = hit_q;
  assign dtack_n = dtack_n_q;

endmodule
`default_nettype wire
